alu_seq: RTL and testbench

Parametrised, handshaked successor to the combinational `Alu`. It executes the same `alufn` operation set at configurable `WIDTH` and adds a signed divide. Single-cycle operations return one cycle after acceptance; MUL and DIV run iteratively, one bit per cycle. The block sits between operand fetch and writeback in the pipelined datapath; result and flags are registered and held until consumed.

---
 rtl/alu_seq.sv | 174 +++++++++++++++++
 tb/tb_alu_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arith/shift/compare ops, plus iterative
// signed MUL (shift-add) and DIV (restoring), one bit per cycle on operand magnitudes.
module alu_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       alufn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu,
  output logic             z,
  output logic             v,
  output logic             n
);

  localparam logic [5:0] OpAdd = 6'b000000, OpSub = 6'b000001, OpMul = 6'b000010;
  localparam logic [5:0] OpDiv = 6'b000011, OpAnd = 6'b011000, OpOr  = 6'b011110;
  localparam logic [5:0] OpXor = 6'b010110, OpA   = 6'b011010, OpShl = 6'b100000;
  localparam logic [5:0] OpShr = 6'b100001, OpSra = 6'b100011, OpEq  = 6'b110011;
  localparam logic [5:0] OpLt  = 6'b110101, OpLe  = 6'b110111;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                 state_q, state_d;
  logic [SHW-1:0]         cnt_q, cnt_d;
  logic [2*WIDTH-1:0]     p_q, p_d;     // MUL: {acc, multiplier}; DIV: {rem, dividend/quotient}
  logic [WIDTH-1:0]       m_q, m_d;     // multiplicand / divisor magnitude
  logic                   neg_q, neg_d, div_q, div_d, ovf_q, ovf_d;
  logic [WIDTH-1:0]       alu_q, alu_d;
  logic                   v_q, v_d;

  logic                   accept, b_zero, a_min, iterative;
  logic [WIDTH-1:0]       sum, dif, a_mag, b_mag, res_s, quo, quo_s;
  logic                   v_s;
  logic [WIDTH:0]         msum, rem_sh, rdiff;
  logic [2*WIDTH-1:0]     mul_nxt, div_nxt, prod_s;
  logic [WIDTH-1:0]       rem;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == StDone);
  assign alu       = alu_q;
  assign v         = v_q;
  assign z         = (alu_q == '0);
  assign n         = alu_q[WIDTH-1];

  assign b_zero    = (b == '0);
  assign a_min     = (a == {1'b1, {(WIDTH-1){1'b0}}});
  assign iterative = (alufn == OpMul) || ((alufn == OpDiv) && !b_zero);
  assign sum       = a + b;
  assign dif       = a - b;
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;

  always_comb begin
    res_s = '0;
    v_s   = 1'b0;
    case (alufn)
      OpAdd: begin
        res_s = sum;
        v_s   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub: begin
        res_s = dif;
        v_s   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
      OpDiv: begin  // only reached here for divide-by-zero
        res_s = '1;
        v_s   = 1'b1;
      end
      OpAnd: res_s = a & b;
      OpOr:  res_s = a | b;
      OpXor: res_s = a ^ b;
      OpA:   res_s = a;
      OpShl: res_s = a << b[SHW-1:0];
      OpShr: res_s = a >> b[SHW-1:0];
      OpSra: res_s = $unsigned($signed(a) >>> b[SHW-1:0]);
      OpEq:  res_s = {{(WIDTH-1){1'b0}}, (a == b)};
      OpLt:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OpLe:  res_s = {{(WIDTH-1){1'b0}}, ($signed(a) <= $signed(b))};
      default: ;
    endcase
  end

  always_comb begin
    msum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    mul_nxt = {msum, p_q[WIDTH-1:1]};
    rem_sh  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    rdiff   = rem_sh - {1'b0, m_q};
    rem     = rdiff[WIDTH] ? rem_sh[WIDTH-1:0] : rdiff[WIDTH-1:0];
    div_nxt = {rem, p_q[WIDTH-2:0], ~rdiff[WIDTH]};
    prod_s  = neg_q ? -mul_nxt : mul_nxt;
    quo     = div_nxt[WIDTH-1:0];
    quo_s   = neg_q ? -quo : quo;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    m_d     = m_q;
    neg_d   = neg_q;
    div_d   = div_q;
    ovf_d   = ovf_q;
    alu_d   = alu_q;
    v_d     = v_q;
    unique case (state_q)
      StBusy: begin
        p_d   = div_q ? div_nxt : mul_nxt;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = StDone;
          if (div_q) begin
            alu_d = quo_s;
            v_d   = ovf_q;
          end else begin
            alu_d = prod_s[WIDTH-1:0];
            v_d   = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
          end
        end
      end
      default: begin  // StIdle, StDone
        if (accept) begin
          if (iterative) begin
            state_d = StBusy;
            cnt_d   = SHW'(WIDTH - 1);
            p_d     = {{WIDTH{1'b0}}, (alufn == OpDiv) ? a_mag : b_mag};
            m_d     = (alufn == OpDiv) ? b_mag : a_mag;
            neg_d   = a[WIDTH-1] ^ b[WIDTH-1];
            div_d   = (alufn == OpDiv);
            ovf_d   = a_min && (b == '1);
          end else begin
            state_d = StDone;
            alu_d   = res_s;
            v_d     = v_s;
          end
        end else if (state_q == StDone && out_ready) begin
          state_d = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      m_q     <= '0;
      neg_q   <= 1'b0;
      div_q   <= 1'b0;
      ovf_q   <= 1'b0;
      alu_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      m_q     <= m_d;
      neg_q   <= neg_d;
      div_q   <= div_d;
      ovf_q   <= ovf_d;
      alu_q   <= alu_d;
      v_q     <= v_d;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=32.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, z, v, n;
  logic [5:0]  alufn;
  logic [31:0] a, b, alu;
  int          checks = 0;
  int          errors = 0;

  alu_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .alufn(alufn),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .alu(alu),
    .z(z), .v(v), .n(n)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one op, wait for the result; lat counts edges from presentation to out_valid.
  task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] ia,
                       input logic [31:0] ib, output int lat, output bit rdy_seen);
    check({tag, " in_ready"}, in_ready, 1);
    alufn = op; a = ia; b = ib; in_valid = 1'b1;
    step();
    in_valid = 1'b0; a = 32'hdead_beef; b = 32'h0; alufn = 6'h3f;
    lat = 1;
    rdy_seen = 0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1;
      step();
      lat++;
    end
  endtask

  task automatic expect_res(input string tag, input int lat, input int exp_lat,
                            input logic [31:0] r, input logic ev, input logic ez,
                            input logic en);
    check({tag, " lat"}, lat, exp_lat);
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " alu"}, alu, r);
    check({tag, " vzn"}, {v, z, n}, {ev, ez, en});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  int lat;
  bit rdy;
  bit seen;
  logic [31:0] xa [4] = '{32'h0000_00ff, 32'h1234_5678, 32'hffff_0000, 32'h8000_0001};
  logic [31:0] xb [4] = '{32'h0000_0f0f, 32'h1111_1111, 32'h00ff_ff00, 32'h8000_0001};
  logic [31:0] xr [4] = '{32'h0000_0ff0, 32'h0325_4769, 32'hff00_ff00, 32'h0000_0000};

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alufn = '0; a = '0; b = '0;
    step(); step();
    reset = 1'b0;
    step();
    check("reset out_valid", out_valid, 0);
    check("reset alu", alu, 0);
    check("reset vzn", {v, z, n}, 3'b010);
    check("reset in_ready", in_ready, 1);

    // ADD overflow, then hold it under back-pressure
    issue("add", 6'b000000, 32'h7fff_ffff, 32'h0000_0001, lat, rdy);
    for (int i = 0; i < 5; i++) begin
      check("hold alu", alu, 32'h8000_0000);
      check("hold vzn", {v, z, n}, 3'b101);
      check("hold in_ready", in_ready, 0);
      check("hold out_valid", out_valid, 1);
      step();
    end
    expect_res("add", lat, 1, 32'h8000_0000, 1, 0, 1);

    issue("sub", 6'b000001, 32'hffff_ff68, 32'hffff_ff34, lat, rdy);
    expect_res("sub", lat, 1, 32'h0000_0034, 0, 0, 0);

    issue("mul", 6'b000010, 32'hffff_ff68, 32'hffff_ff34, lat, rdy);
    check("mul busy in_ready", rdy, 0);
    expect_res("mul", lat, 33, 32'h0000_7920, 0, 0, 0);
    issue("mul ovf", 6'b000010, 32'h0001_0000, 32'h0001_0000, lat, rdy);
    expect_res("mul ovf", lat, 33, 32'h0, 1, 1, 0);

    issue("div", 6'b000011, 32'hffff_fff9, 32'h0000_0002, lat, rdy);
    check("div busy in_ready", rdy, 0);
    expect_res("div", lat, 33, 32'hffff_fffd, 0, 0, 1);
    issue("div min", 6'b000011, 32'h8000_0000, 32'hffff_ffff, lat, rdy);
    expect_res("div min", lat, 33, 32'h8000_0000, 1, 0, 1);
    issue("div zero", 6'b000011, 32'h0000_1234, 32'h0, lat, rdy);
    expect_res("div zero", lat, 1, 32'hffff_ffff, 1, 0, 1);

    issue("sra", 6'b100011, 32'hffff_ff68, 32'd8, lat, rdy);
    expect_res("sra", lat, 1, 32'hffff_ffff, 0, 0, 1);
    issue("shr", 6'b100001, 32'hffff_ff68, 32'd8, lat, rdy);
    expect_res("shr", lat, 1, 32'h00ff_ffff, 0, 0, 0);
    issue("shl", 6'b100000, 32'h0000_0001, 32'd31, lat, rdy);
    expect_res("shl", lat, 1, 32'h8000_0000, 0, 0, 1);
    issue("cmplt", 6'b110101, 32'hff00_ffff, 32'hffff_ff34, lat, rdy);
    expect_res("cmplt", lat, 1, 32'h1, 0, 0, 0);
    issue("cmpeq", 6'b110011, 32'h0a0a_0a0a, 32'h0a0a_0a0a, lat, rdy);
    expect_res("cmpeq", lat, 1, 32'h1, 0, 0, 0);
    issue("cmple", 6'b110111, 32'hffff_ffff, 32'hffff_ffff, lat, rdy);
    expect_res("cmple", lat, 1, 32'h1, 0, 0, 0);
    issue("bad op", 6'b111111, 32'h1234_5678, 32'h1, lat, rdy);
    expect_res("bad op", lat, 1, 32'h0, 0, 1, 0);

    // Back-to-back XOR stream, one result per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      alufn = 6'b010110; a = xa[i]; b = xb[i]; in_valid = 1'b1;
      check("xor in_ready", in_ready, 1);
      step();
      check("xor out_valid", out_valid, 1);
      check("xor alu", alu, xr[i]);
    end
    in_valid = 1'b0;
    step();
    check("xor drained", out_valid, 0);
    out_ready = 1'b0;

    // Reset during MUL iteration 10
    alufn = 6'b000010; a = 32'h0000_0123; b = 32'h0000_0456; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst mul out_valid", out_valid, 0);
    check("rst mul alu", alu, 0);
    check("rst mul vzn", {v, z, n}, 3'b010);
    check("rst mul in_ready", in_ready, 1);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1;
      step();
    end
    check("rst mul no pulse", seen, 0);
    issue("add after rst", 6'b000000, 32'd2, 32'd3, lat, rdy);
    expect_res("add after rst", lat, 1, 32'd5, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
